// File: rtl/piggy_pkg.sv
// Shared types for the piggy-bank controller: FSM state encoding and coin denominations.
// The coin_value() helper maps a 2-bit denomination code to its value in balance units.
package piggy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADD     = 3'd1,
        ST_SUB     = 3'd2,
        ST_RESP    = 3'd3,
        ST_LOCKOUT = 3'd4
    } piggy_state_t;

    localparam int DEF_BAL_W = 8;

    localparam logic [1:0] DENOM_1  = 2'b00;
    localparam logic [1:0] DENOM_5  = 2'b01;
    localparam logic [1:0] DENOM_10 = 2'b10;
    localparam logic [1:0] DENOM_25 = 2'b11;

    function automatic logic [DEF_BAL_W-1:0] coin_value(input logic [1:0] denom);
        logic [DEF_BAL_W-1:0] val;
        case (denom)
            DENOM_1:  val = DEF_BAL_W'(1);
            DENOM_5:  val = DEF_BAL_W'(5);
            DENOM_10: val = DEF_BAL_W'(10);
            default:  val = DEF_BAL_W'(25);
        endcase
        return val;
    endfunction

endpackage

// File: rtl/piggy_lockout_timer.sv
// Lockout countdown: load sets LOCK_CYCLES-1, then decrements once per enabled cycle while dec_i.
// done_o is high when the count has reached zero; ena=0 freezes the count.
module piggy_lockout_timer
    import piggy_pkg::*;
#(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            if (load_i) begin
                cnt_q <= LOAD_VAL;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/piggy_txn_ctrl.sv
// Piggy-bank transaction controller: accepts deposits/withdrawals, answers with a 1-cycle ack/deny.
// Accept edge N, balance update at N+1, IDLE again after N+2; requests are held by the requester.
module piggy_txn_ctrl
    import piggy_pkg::*;
#(
    parameter int         BAL_W       = 8,
    parameter logic [3:0] UNLOCK_CODE = 4'hA,
    parameter int         MAX_FAILS   = 3,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             coin_valid,
    input  logic [1:0]       coin_denom,
    input  logic             wd_req,
    input  logic [BAL_W-1:0] wd_amt,
    input  logic [3:0]       wd_code,
    output logic [BAL_W-1:0] balance,
    output logic             busy,
    output logic             ack,
    output logic             deny,
    output logic             locked
);

    localparam int FC_W = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
    localparam logic [FC_W-1:0]  MAX_FAILS_C = FC_W'(MAX_FAILS);
    localparam logic [BAL_W:0]   MAX_BAL     = {1'b0, {BAL_W{1'b1}}};

    piggy_state_t     state_q;
    logic [BAL_W-1:0] bal_q;
    logic [FC_W-1:0]  fail_cnt_q;
    logic             lock_pend_q;
    logic [1:0]       denom_q;
    logic [BAL_W-1:0] amt_q;
    logic [3:0]       code_q;
    logic             busy_q;
    logic             ack_q;
    logic             deny_q;
    logic             locked_q;

    logic [BAL_W:0]   add_sum;
    logic [FC_W-1:0]  fail_inc;
    logic             lock_done;
    logic             lock_load;

    // One extra bit so an overflowing deposit is detected rather than wrapped.
    assign add_sum   = {1'b0, bal_q} + (BAL_W+1)'(coin_value(denom_q));
    assign fail_inc  = fail_cnt_q + FC_W'(1);
    assign lock_load = (state_q == ST_RESP) && lock_pend_q;

    piggy_lockout_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lockout_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .load_i (lock_load),
        .dec_i  (state_q == ST_LOCKOUT),
        .done_o (lock_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bal_q       <= '0;
            fail_cnt_q  <= '0;
            lock_pend_q <= 1'b0;
            denom_q     <= '0;
            amt_q       <= '0;
            code_q      <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            deny_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else if (ena) begin
            ack_q  <= 1'b0;
            deny_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Deposits take priority; a simultaneous withdrawal stays pending.
                    if (coin_valid) begin
                        state_q <= ST_ADD;
                        busy_q  <= 1'b1;
                        denom_q <= coin_denom;
                    end else if (wd_req) begin
                        state_q <= ST_SUB;
                        busy_q  <= 1'b1;
                        amt_q   <= wd_amt;
                        code_q  <= wd_code;
                    end
                end
                ST_ADD: begin
                    state_q <= ST_RESP;
                    if (add_sum > MAX_BAL) begin
                        deny_q <= 1'b1;
                    end else begin
                        bal_q <= add_sum[BAL_W-1:0];
                        ack_q <= 1'b1;
                    end
                end
                ST_SUB: begin
                    state_q <= ST_RESP;
                    if (code_q != UNLOCK_CODE) begin
                        deny_q     <= 1'b1;
                        fail_cnt_q <= fail_inc;
                        if (fail_inc == MAX_FAILS_C) begin
                            lock_pend_q <= 1'b1;
                        end
                    end else if (amt_q > bal_q) begin
                        deny_q <= 1'b1;
                    end else begin
                        bal_q      <= bal_q - amt_q;
                        ack_q      <= 1'b1;
                        fail_cnt_q <= '0;
                    end
                end
                ST_RESP: begin
                    if (lock_pend_q) begin
                        state_q     <= ST_LOCKOUT;
                        locked_q    <= 1'b1;
                        lock_pend_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_done) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        locked_q   <= 1'b0;
                        fail_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign balance = bal_q;
    assign busy    = busy_q;
    assign ack     = ack_q;
    assign deny    = deny_q;
    assign locked  = locked_q;

endmodule
